// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct constants, ALU encodings and decode control bundle
package mips_pkg;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_XOR  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SUB  = 4'b0100,
    ALU_NOR  = 4'b0101,
    ALU_SLT  = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_BEQ  = 4'b1010,
    ALU_BNE  = 4'b1011,
    ALU_RSVD = 4'b1100,
    ALU_JMP  = 4'b1101,
    ALU_JR   = 4'b1110,
    ALU_NOP  = 4'b1111
  } alu_ctrl_t;

  typedef struct packed {
    logic      reg_write;
    logic      reg_dst;
    logic      alu_src;
    logic      shamt_src;
    logic      zero_ext;
    logic      mem_to_reg;
    logic      mem_write;
    logic      branch;
    logic      jump;
    logic      jump_reg;
    logic      link;
    alu_ctrl_t alu_control;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_write: 1'b0, reg_dst: 1'b0, alu_src: 1'b0, shamt_src: 1'b0,
    zero_ext: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0, branch: 1'b0,
    jump: 1'b0, jump_reg: 1'b0, link: 1'b0, alu_control: ALU_NOP
  };

endpackage

// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - ID-side operands in, EX/MEM register and jump outputs
interface execute_stage_if;
  logic [31:0] in_inst;
  logic [31:0] in_RD1;
  logic [31:0] in_RD2;
  logic [31:0] in_PCplus4;
  logic        RegWrite;
  logic        MemtoReg;
  logic        MemWrite;
  logic        Branch;
  logic [31:0] ALUOut;
  logic        zero;
  logic [31:0] WriteData;
  logic [4:0]  WriteReg;
  logic [31:0] PCBranch;
  logic        Jump;
  logic        JumpReg;
  logic [31:0] JumpTarget;

  modport master (
    output in_inst, in_RD1, in_RD2, in_PCplus4,
    input  RegWrite, MemtoReg, MemWrite, Branch, ALUOut, zero,
    input  WriteData, WriteReg, PCBranch, Jump, JumpReg, JumpTarget
  );

  modport slave (
    input  in_inst, in_RD1, in_RD2, in_PCplus4,
    output RegWrite, MemtoReg, MemWrite, Branch, ALUOut, zero,
    output WriteData, WriteReg, PCBranch, Jump, JumpReg, JumpTarget
  );
endinterface

// File: rtl/execute_stage_alu.sv
// rtl/execute_stage_alu.sv - 32-bit ALU producing result C and zero flag
module alu
  import mips_pkg::*;
(
  input  logic [31:0] Ain,
  input  logic [31:0] Bin,
  input  alu_ctrl_t   ALUControl,
  output logic [31:0] C,
  output logic        zero
);

  always_comb begin
    C = 32'd0;
    unique case (ALUControl)
      ALU_ADD:          C = Ain + Bin;
      ALU_SUB, ALU_BEQ,
      ALU_BNE:          C = Ain - Bin;
      ALU_AND:          C = Ain & Bin;
      ALU_OR:           C = Ain | Bin;
      ALU_XOR:          C = Ain ^ Bin;
      ALU_NOR:          C = ~(Ain | Bin);
      ALU_SLT:          C = {31'd0, $signed(Ain) < $signed(Bin)};
      ALU_SLL:          C = Bin << Ain[4:0];
      ALU_SRL:          C = Bin >> Ain[4:0];
      ALU_SRA:          C = $unsigned($signed(Bin) >>> Ain[4:0]);
      default:          C = 32'd0;
    endcase
  end

  // Jump/reserved encodings force zero low so they can never look like a taken beq.
  always_comb begin
    zero = 1'b0;
    unique case (ALUControl)
      ALU_BNE:                             zero = (C != 32'd0);
      ALU_RSVD, ALU_JMP, ALU_JR, ALU_NOP:  zero = 1'b0;
      default:                             zero = (C == 32'd0);
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - decode, operand select, ALU and EX/MEM register
module execute_stage
  import mips_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  execute_stage_if.slave    bus
);

  ctrl_t       ctrl;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] imm_ext;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] alu_c;
  logic        alu_zero;
  logic [31:0] ex_result;
  logic [4:0]  ex_write_reg;
  logic [31:0] ex_pc_branch;

  assign opcode = bus.in_inst[31:26];
  assign funct  = bus.in_inst[5:0];
  assign imm    = bus.in_inst[15:0];

  always_comb begin
    ctrl = CTRL_NOP;
    if (bus.in_inst != HALT_WORD) begin
      unique case (opcode)
        OP_RTYPE: begin
          ctrl.reg_dst   = 1'b1;
          ctrl.reg_write = 1'b1;
          unique case (funct)
            FN_ADD, FN_ADDU:  ctrl.alu_control = ALU_ADD;
            FN_SUB, FN_SUBU:  ctrl.alu_control = ALU_SUB;
            FN_AND:           ctrl.alu_control = ALU_AND;
            FN_OR:            ctrl.alu_control = ALU_OR;
            FN_XOR:           ctrl.alu_control = ALU_XOR;
            FN_NOR:           ctrl.alu_control = ALU_NOR;
            FN_SLT:           ctrl.alu_control = ALU_SLT;
            FN_SLLV:          ctrl.alu_control = ALU_SLL;
            FN_SRLV:          ctrl.alu_control = ALU_SRL;
            FN_SRAV:          ctrl.alu_control = ALU_SRA;
            FN_SLL: begin
              ctrl.alu_control = ALU_SLL;
              ctrl.shamt_src   = 1'b1;
            end
            FN_SRL: begin
              ctrl.alu_control = ALU_SRL;
              ctrl.shamt_src   = 1'b1;
            end
            FN_SRA: begin
              ctrl.alu_control = ALU_SRA;
              ctrl.shamt_src   = 1'b1;
            end
            FN_JR: begin
              ctrl.alu_control = ALU_JR;
              ctrl.reg_write   = 1'b0;
              ctrl.jump_reg    = 1'b1;
            end
            default:          ctrl = CTRL_NOP;
          endcase
        end
        OP_ADDI, OP_ADDIU: begin
          ctrl.reg_write   = 1'b1;
          ctrl.alu_src     = 1'b1;
          ctrl.alu_control = ALU_ADD;
        end
        OP_ANDI, OP_ORI, OP_XORI: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.zero_ext  = 1'b1;
          ctrl.alu_control = (opcode == OP_ANDI) ? ALU_AND :
                             (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
        end
        OP_LW: begin
          ctrl.reg_write   = 1'b1;
          ctrl.alu_src     = 1'b1;
          ctrl.mem_to_reg  = 1'b1;
          ctrl.alu_control = ALU_ADD;
        end
        OP_SW: begin
          ctrl.alu_src     = 1'b1;
          ctrl.mem_write   = 1'b1;
          ctrl.alu_control = ALU_ADD;
        end
        OP_BEQ, OP_BNE: begin
          ctrl.branch      = 1'b1;
          ctrl.alu_control = (opcode == OP_BEQ) ? ALU_BEQ : ALU_BNE;
        end
        OP_J: begin
          ctrl.jump        = 1'b1;
          ctrl.alu_control = ALU_JMP;
        end
        OP_JAL: begin
          ctrl.jump        = 1'b1;
          ctrl.link        = 1'b1;
          ctrl.reg_write   = 1'b1;
          ctrl.alu_control = ALU_JMP;
        end
        default: ctrl = CTRL_NOP;
      endcase
    end
  end

  assign imm_ext = ctrl.zero_ext ? {16'd0, imm} : {{16{imm[15]}}, imm};
  assign src_a   = ctrl.shamt_src ? {27'd0, bus.in_inst[10:6]} : bus.in_RD1;
  assign src_b   = ctrl.alu_src ? imm_ext : bus.in_RD2;

  alu u_alu (
    .Ain        (src_a),
    .Bin        (src_b),
    .ALUControl (ctrl.alu_control),
    .C          (alu_c),
    .zero       (alu_zero)
  );

  // jal returns its link address through the ALU result path.
  assign ex_result    = ctrl.link ? bus.in_PCplus4 : alu_c;
  assign ex_write_reg = ctrl.link    ? 5'd31 :
                        ctrl.reg_dst ? bus.in_inst[15:11] : bus.in_inst[20:16];
  assign ex_pc_branch = bus.in_PCplus4 + {{14{imm[15]}}, imm, 2'b00};

  assign bus.Jump       = ctrl.jump;
  assign bus.JumpReg    = ctrl.jump_reg;
  assign bus.JumpTarget = ctrl.jump     ? {bus.in_PCplus4[31:28], bus.in_inst[25:0], 2'b00} :
                          ctrl.jump_reg ? bus.in_RD1 : 32'd0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bus.RegWrite  <= 1'b0;
      bus.MemtoReg  <= 1'b0;
      bus.MemWrite  <= 1'b0;
      bus.Branch    <= 1'b0;
      bus.ALUOut    <= 32'd0;
      bus.zero      <= 1'b0;
      bus.WriteData <= 32'd0;
      bus.WriteReg  <= 5'd0;
      bus.PCBranch  <= 32'd0;
    end else if (FLUSH) begin
      bus.RegWrite  <= 1'b0;
      bus.MemtoReg  <= 1'b0;
      bus.MemWrite  <= 1'b0;
      bus.Branch    <= 1'b0;
      bus.ALUOut    <= 32'd0;
      bus.zero      <= 1'b0;
      bus.WriteData <= 32'd0;
      bus.WriteReg  <= 5'd0;
      bus.PCBranch  <= 32'd0;
    end else begin
      bus.RegWrite  <= ctrl.reg_write;
      bus.MemtoReg  <= ctrl.mem_to_reg;
      bus.MemWrite  <= ctrl.mem_write;
      bus.Branch    <= ctrl.branch;
      bus.ALUOut    <= ex_result;
      bus.zero      <= alu_zero;
      bus.WriteData <= bus.in_RD2;
      bus.WriteReg  <= ex_write_reg;
      bus.PCBranch  <= ex_pc_branch;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed-vector bench for execute_stage
module tb_execute_stage;

  logic CLK;
  logic RESET;
  logic FLUSH;
  int   vectors;
  int   errors;

  execute_stage_if eif ();

  execute_stage dut (
    .CLK   (CLK),
    .RESET (RESET),
    .FLUSH (FLUSH),
    .bus   (eif.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic drive(input logic [31:0] inst, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [31:0] pc4);
    eif.in_inst    = inst;
    eif.in_RD1     = rd1;
    eif.in_RD2     = rd2;
    eif.in_PCplus4 = pc4;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    FLUSH = 1'b0;
    drive(32'h2008FFFF, 32'd5, 32'd9, 32'h40);
    repeat (2) @(negedge CLK);
    vectors++;
    if ({eif.RegWrite, eif.MemtoReg, eif.MemWrite, eif.Branch, eif.zero} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000",
        {eif.RegWrite, eif.MemtoReg, eif.MemWrite, eif.Branch, eif.zero});
    end
    vectors++;
    if ({eif.ALUOut, eif.WriteData, eif.PCBranch, eif.WriteReg} !== 101'd0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h/%h expected zeros",
        eif.ALUOut, eif.WriteData, eif.PCBranch, eif.WriteReg);
    end
    RESET = 1'b1;
  endtask

  task automatic test_addi();
    drive(32'h2008FFFF, 32'd5, 32'd0, 32'h40);
    @(posedge CLK); #1;
    vectors++;
    if (eif.ALUOut !== 32'd4 || eif.RegWrite !== 1'b1 || eif.WriteReg !== 5'd8) begin
      errors++; $display("FAIL addi: got ALUOut=%h RegWrite=%b WriteReg=%0d expected 4/1/8",
        eif.ALUOut, eif.RegWrite, eif.WriteReg);
    end
  endtask

  task automatic test_ori();
    drive(32'h3408FFFF, 32'd0, 32'd0, 32'h40);
    @(posedge CLK); #1;
    vectors++;
    if (eif.ALUOut !== 32'h0000FFFF || eif.RegWrite !== 1'b1) begin
      errors++; $display("FAIL ori: got ALUOut=%h RegWrite=%b expected 0000ffff/1",
        eif.ALUOut, eif.RegWrite);
    end
  endtask

  task automatic test_rtype();
    logic [31:0] inst_t [5] = '{32'h00084080, 32'h01095022, 32'h0109502A,
                                32'h00095103, 32'h01095027};
    logic [31:0] rd1_t  [5] = '{32'd0, 32'd5, 32'hFFFFFFFF, 32'd0, 32'd5};
    logic [31:0] rd2_t  [5] = '{32'd3, 32'd7, 32'd7, 32'h80000000, 32'd7};
    logic [31:0] exp_t  [5] = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'hF8000000, 32'hFFFFFFF8};
    logic [4:0]  wr_t   [5] = '{5'd8, 5'd10, 5'd10, 5'd10, 5'd10};
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      drive(inst_t[i], rd1_t[i], rd2_t[i], 32'h40);
      @(posedge CLK); #1;
      vectors++;
      if (eif.ALUOut !== exp_t[i] || eif.WriteReg !== wr_t[i] || eif.RegWrite !== 1'b1) begin
        errors++; $display("FAIL rtype[%0d]: got ALUOut=%h WriteReg=%0d RegWrite=%b expected %h/%0d/1",
          i, eif.ALUOut, eif.WriteReg, eif.RegWrite, exp_t[i], wr_t[i]);
      end
    end
  endtask

  task automatic test_branch();
    @(negedge CLK);
    drive(32'h11090003, 32'd7, 32'd7, 32'h100);
    @(posedge CLK); #1;
    vectors++;
    if (eif.zero !== 1'b1 || eif.Branch !== 1'b1 || eif.PCBranch !== 32'h10C || eif.RegWrite !== 1'b0) begin
      errors++; $display("FAIL beq: got zero=%b Branch=%b PCBranch=%h RegWrite=%b expected 1/1/10c/0",
        eif.zero, eif.Branch, eif.PCBranch, eif.RegWrite);
    end
    @(negedge CLK);
    drive(32'h15090003, 32'd7, 32'd7, 32'h100);
    @(posedge CLK); #1;
    vectors++;
    if (eif.zero !== 1'b0 || eif.Branch !== 1'b1) begin
      errors++; $display("FAIL bne: got zero=%b Branch=%b expected 0/1", eif.zero, eif.Branch);
    end
  endtask

  task automatic test_jump();
    @(negedge CLK);
    drive(32'h0C000040, 32'd0, 32'd0, 32'h20);
    #1;
    vectors++;
    if (eif.Jump !== 1'b1 || eif.JumpReg !== 1'b0 || eif.JumpTarget !== 32'h100) begin
      errors++; $display("FAIL jal_comb: got Jump=%b JumpReg=%b JumpTarget=%h expected 1/0/100",
        eif.Jump, eif.JumpReg, eif.JumpTarget);
    end
    @(posedge CLK); #1;
    vectors++;
    if (eif.WriteReg !== 5'd31 || eif.ALUOut !== 32'h20 || eif.RegWrite !== 1'b1 || eif.zero !== 1'b0) begin
      errors++; $display("FAIL jal_reg: got WriteReg=%0d ALUOut=%h RegWrite=%b zero=%b expected 31/20/1/0",
        eif.WriteReg, eif.ALUOut, eif.RegWrite, eif.zero);
    end
    @(negedge CLK);
    drive(32'h01000008, 32'h1234, 32'd0, 32'h20);
    #1;
    vectors++;
    if (eif.Jump !== 1'b0 || eif.JumpReg !== 1'b1 || eif.JumpTarget !== 32'h1234) begin
      errors++; $display("FAIL jr_comb: got Jump=%b JumpReg=%b JumpTarget=%h expected 0/1/1234",
        eif.Jump, eif.JumpReg, eif.JumpTarget);
    end
    @(posedge CLK); #1;
    vectors++;
    if (eif.RegWrite !== 1'b0 || eif.ALUOut !== 32'd0) begin
      errors++; $display("FAIL jr_reg: got RegWrite=%b ALUOut=%h expected 0/0", eif.RegWrite, eif.ALUOut);
    end
  endtask

  task automatic test_sw_flush();
    @(negedge CLK);
    drive(32'hAD090004, 32'h100, 32'hDEADBEEF, 32'h40);
    @(posedge CLK); #1;
    vectors++;
    if (eif.RegWrite !== 1'b0 || eif.MemWrite !== 1'b1 || eif.WriteData !== 32'hDEADBEEF || eif.ALUOut !== 32'h104) begin
      errors++; $display("FAIL sw: got RegWrite=%b MemWrite=%b WriteData=%h ALUOut=%h expected 0/1/deadbeef/104",
        eif.RegWrite, eif.MemWrite, eif.WriteData, eif.ALUOut);
    end
    @(negedge CLK);
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    vectors++;
    if ({eif.RegWrite, eif.MemtoReg, eif.MemWrite, eif.Branch, eif.zero} !== 5'b0 ||
        {eif.ALUOut, eif.WriteData, eif.PCBranch, eif.WriteReg} !== 101'd0) begin
      errors++; $display("FAIL flush: got ctrl=%b ALUOut=%h WriteData=%h PCBranch=%h WriteReg=%0d expected zeros",
        {eif.RegWrite, eif.MemtoReg, eif.MemWrite, eif.Branch, eif.zero},
        eif.ALUOut, eif.WriteData, eif.PCBranch, eif.WriteReg);
    end
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    drive(32'h8D0A0008, 32'h200, 32'd0, 32'h40);
    @(posedge CLK); #1;
    vectors++;
    if (eif.ALUOut !== 32'h208 || eif.MemtoReg !== 1'b1 || eif.RegWrite !== 1'b1 || eif.WriteReg !== 5'd10) begin
      errors++; $display("FAIL lw: got ALUOut=%h MemtoReg=%b RegWrite=%b WriteReg=%0d expected 208/1/1/10",
        eif.ALUOut, eif.MemtoReg, eif.RegWrite, eif.WriteReg);
    end
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    vectors++;
    if ({eif.RegWrite, eif.MemtoReg, eif.ALUOut, eif.WriteReg} !== 39'd0) begin
      errors++; $display("FAIL async_reset: got RegWrite=%b MemtoReg=%b ALUOut=%h WriteReg=%0d expected zeros",
        eif.RegWrite, eif.MemtoReg, eif.ALUOut, eif.WriteReg);
    end
    @(posedge CLK); #1;
    vectors++;
    if (eif.ALUOut !== 32'd0 || eif.RegWrite !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got ALUOut=%h RegWrite=%b expected 0/0", eif.ALUOut, eif.RegWrite);
    end
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    vectors++;
    if (eif.ALUOut !== 32'h208 || eif.MemtoReg !== 1'b1) begin
      errors++; $display("FAIL reset_resume: got ALUOut=%h MemtoReg=%b expected 208/1", eif.ALUOut, eif.MemtoReg);
    end
  endtask

  task automatic test_halt();
    @(negedge CLK);
    drive(32'hFFFFFFFF, 32'd5, 32'd7, 32'h40);
    #1;
    vectors++;
    if (eif.Jump !== 1'b0 || eif.JumpReg !== 1'b0) begin
      errors++; $display("FAIL halt_comb: got Jump=%b JumpReg=%b expected 0/0", eif.Jump, eif.JumpReg);
    end
    @(posedge CLK); #1;
    vectors++;
    if ({eif.RegWrite, eif.MemtoReg, eif.MemWrite, eif.Branch, eif.zero} !== 5'b0 || eif.ALUOut !== 32'd0) begin
      errors++; $display("FAIL halt_reg: got ctrl=%b ALUOut=%h expected 00000/0",
        {eif.RegWrite, eif.MemtoReg, eif.MemWrite, eif.Branch, eif.zero}, eif.ALUOut);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    @(negedge CLK);
    test_addi();
    @(negedge CLK);
    test_ori();
    test_rtype();
    test_branch();
    test_jump();
    test_sw_flush();
    test_async_reset();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
